// File: rtl/sys_control_rx.sv
// Receive-side command decoder for the system UART link: parses command frames into
// register-file writes/reads and ALU starts, and returns results to the transmit block.
module sys_control_rx #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned ADDR    = 4,
   parameter int unsigned FUN_W   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     uart_rx_data_in,
   input  logic                 uart_rx_data_valid_in,
   output logic                 rf_wr_en_out,
   output logic                 rf_rd_en_out,
   output logic [ADDR-1:0]      rf_addr_out,
   output logic [WIDTH-1:0]     rf_wr_data_out,
   input  logic [WIDTH-1:0]     rf_rd_data_in,
   input  logic                 rf_rd_data_valid_in,
   output logic                 alu_en_out,
   output logic [FUN_W-1:0]     alu_fun_out,
   input  logic [2*WIDTH-1:0]   alu_out_in,
   input  logic                 alu_out_valid_in,
   output logic                 clk_gate_en_out,
   output logic                 uart_rf_send_out,
   output logic [WIDTH-1:0]     uart_rf_send_data_out,
   output logic                 uart_alu_send_out,
   output logic [2*WIDTH-1:0]   uart_alu_send_data_out,
   output logic                 timeout_err_out
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [WIDTH-1:0] CMD_RF_WR  = WIDTH'(8'hAA);
   localparam logic [WIDTH-1:0] CMD_RF_RD  = WIDTH'(8'hBB);
   localparam logic [WIDTH-1:0] CMD_ALU_OP = WIDTH'(8'hCC);
   localparam logic [WIDTH-1:0] CMD_ALU_NO = WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StRdAddr,
      StRdWait,
      StOpA,
      StOpB,
      StFun,
      StAluWait
   } state_e;

   state_e           state;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                  <= StIdle;
         wait_cnt               <= '0;
         rf_wr_en_out           <= 1'b0;
         rf_rd_en_out           <= 1'b0;
         rf_addr_out            <= '0;
         rf_wr_data_out         <= '0;
         alu_en_out             <= 1'b0;
         alu_fun_out            <= '0;
         clk_gate_en_out        <= 1'b0;
         uart_rf_send_out       <= 1'b0;
         uart_rf_send_data_out  <= '0;
         uart_alu_send_out      <= 1'b0;
         uart_alu_send_data_out <= '0;
         timeout_err_out        <= 1'b0;
      end else begin
         // Strobes fall back to 0 unless re-asserted below; data outputs hold.
         rf_wr_en_out      <= 1'b0;
         rf_rd_en_out      <= 1'b0;
         alu_en_out        <= 1'b0;
         uart_rf_send_out  <= 1'b0;
         uart_alu_send_out <= 1'b0;
         timeout_err_out   <= 1'b0;

         unique case (state)
            StIdle: begin
               if (uart_rx_data_valid_in) begin
                  case (uart_rx_data_in)
                     CMD_RF_WR: state <= StWrAddr;
                     CMD_RF_RD: state <= StRdAddr;
                     CMD_ALU_OP: begin
                        state           <= StOpA;
                        clk_gate_en_out <= 1'b1;
                     end
                     CMD_ALU_NO: begin
                        state           <= StFun;
                        clk_gate_en_out <= 1'b1;
                     end
                     default: state <= StIdle;
                  endcase
               end
            end

            StWrAddr: begin
               if (uart_rx_data_valid_in) begin
                  rf_addr_out <= uart_rx_data_in[ADDR-1:0];
                  state       <= StWrData;
               end
            end

            StWrData: begin
               if (uart_rx_data_valid_in) begin
                  rf_wr_data_out <= uart_rx_data_in;
                  rf_wr_en_out   <= 1'b1;
                  state          <= StIdle;
               end
            end

            StRdAddr: begin
               if (uart_rx_data_valid_in) begin
                  rf_addr_out  <= uart_rx_data_in[ADDR-1:0];
                  rf_rd_en_out <= 1'b1;
                  wait_cnt     <= '0;
                  state        <= StRdWait;
               end
            end

            StRdWait: begin
               // A valid landing on the timeout cycle still completes the read.
               if (rf_rd_data_valid_in) begin
                  uart_rf_send_data_out <= rf_rd_data_in;
                  uart_rf_send_out      <= 1'b1;
                  state                 <= StIdle;
               end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                  timeout_err_out <= 1'b1;
                  state           <= StIdle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            StOpA: begin
               if (uart_rx_data_valid_in) begin
                  rf_addr_out    <= ADDR'(0);
                  rf_wr_data_out <= uart_rx_data_in;
                  rf_wr_en_out   <= 1'b1;
                  state          <= StOpB;
               end
            end

            StOpB: begin
               if (uart_rx_data_valid_in) begin
                  rf_addr_out    <= ADDR'(1);
                  rf_wr_data_out <= uart_rx_data_in;
                  rf_wr_en_out   <= 1'b1;
                  state          <= StFun;
               end
            end

            StFun: begin
               if (uart_rx_data_valid_in) begin
                  alu_fun_out <= uart_rx_data_in[FUN_W-1:0];
                  alu_en_out  <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= StAluWait;
               end
            end

            StAluWait: begin
               if (alu_out_valid_in) begin
                  uart_alu_send_data_out <= alu_out_in;
                  uart_alu_send_out      <= 1'b1;
                  clk_gate_en_out        <= 1'b0;
                  state                  <= StIdle;
               end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                  timeout_err_out <= 1'b1;
                  clk_gate_en_out <= 1'b0;
                  state           <= StIdle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: begin
               clk_gate_en_out <= 1'b0;
               state           <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_control_rx.sv
// Scoreboard bench for sys_control_rx: stimulus pushes expected strobe events,
// a negedge monitor pops and compares each strobe the DUT raises.
module tb_sys_control_rx;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned ADDR    = 4;
   localparam int unsigned FUN_W   = 4;
   localparam int unsigned TIMEOUT = 255;

   localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_RF_SEND = 3, K_ALU_SEND = 4, K_TO = 5;

   typedef struct {
      int          kind;
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [WIDTH-1:0]     uart_rx_data_in;
   logic                 uart_rx_data_valid_in;
   logic                 rf_wr_en_out;
   logic                 rf_rd_en_out;
   logic [ADDR-1:0]      rf_addr_out;
   logic [WIDTH-1:0]     rf_wr_data_out;
   logic [WIDTH-1:0]     rf_rd_data_in;
   logic                 rf_rd_data_valid_in;
   logic                 alu_en_out;
   logic [FUN_W-1:0]     alu_fun_out;
   logic [2*WIDTH-1:0]   alu_out_in;
   logic                 alu_out_valid_in;
   logic                 clk_gate_en_out;
   logic                 uart_rf_send_out;
   logic [WIDTH-1:0]     uart_rf_send_data_out;
   logic                 uart_alu_send_out;
   logic [2*WIDTH-1:0]   uart_alu_send_data_out;
   logic                 timeout_err_out;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   sys_control_rx #(
      .WIDTH  (WIDTH),
      .ADDR   (ADDR),
      .FUN_W  (FUN_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .uart_rx_data_in       (uart_rx_data_in),
      .uart_rx_data_valid_in (uart_rx_data_valid_in),
      .rf_wr_en_out          (rf_wr_en_out),
      .rf_rd_en_out          (rf_rd_en_out),
      .rf_addr_out           (rf_addr_out),
      .rf_wr_data_out        (rf_wr_data_out),
      .rf_rd_data_in         (rf_rd_data_in),
      .rf_rd_data_valid_in   (rf_rd_data_valid_in),
      .alu_en_out            (alu_en_out),
      .alu_fun_out           (alu_fun_out),
      .alu_out_in            (alu_out_in),
      .alu_out_valid_in      (alu_out_valid_in),
      .clk_gate_en_out       (clk_gate_en_out),
      .uart_rf_send_out      (uart_rf_send_out),
      .uart_rf_send_data_out (uart_rf_send_data_out),
      .uart_alu_send_out     (uart_alu_send_out),
      .uart_alu_send_data_out(uart_alu_send_data_out),
      .timeout_err_out       (timeout_err_out)
   );

   always #5 clk = ~clk;

   function automatic string kind_name(input int k);
      case (k)
         K_WR:       return "rf_wr";
         K_RD:       return "rf_rd";
         K_ALU:      return "alu_en";
         K_RF_SEND:  return "rf_send";
         K_ALU_SEND: return "alu_send";
         default:    return "timeout";
      endcase
   endfunction

   function automatic void push(input int k, input logic [3:0] a, input logic [15:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endfunction

   function automatic void check_evt(input int k, input logic [3:0] a, input logic [15:0] d);
      exp_t e;
      compared++;
      if (q.size() == 0) begin
         mismatched++;
         $display("FAIL %s: unexpected strobe addr=%0h data=%0h, none expected",
                  kind_name(k), a, d);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.addr != a || e.data != d) begin
            mismatched++;
            $display("FAIL %s: got %s addr=%0h data=%0h, expected %s addr=%0h data=%0h",
                     kind_name(e.kind), kind_name(k), a, d, kind_name(e.kind), e.addr, e.data);
         end
      end
   endfunction

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every strobe the DUT raises must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (rf_wr_en_out)      check_evt(K_WR, rf_addr_out, {8'h00, rf_wr_data_out});
         if (rf_rd_en_out)      check_evt(K_RD, rf_addr_out, 16'h0000);
         if (alu_en_out)        check_evt(K_ALU, 4'h0, {12'h000, alu_fun_out});
         if (uart_rf_send_out)  check_evt(K_RF_SEND, 4'h0, {8'h00, uart_rf_send_data_out});
         if (uart_alu_send_out) check_evt(K_ALU_SEND, 4'h0, uart_alu_send_data_out);
         if (timeout_err_out)   check_evt(K_TO, 4'h0, 16'h0000);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      uart_rx_data_in       = b;
      uart_rx_data_valid_in = 1'b1;
      @(negedge clk);
      uart_rx_data_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [63:0] all_outs();
      return {17'h0, rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out, alu_en_out,
              alu_fun_out, clk_gate_en_out, uart_rf_send_out, uart_rf_send_data_out,
              uart_alu_send_out, uart_alu_send_data_out, timeout_err_out};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset                 = 1'b1;
      uart_rx_data_in       = '0;
      uart_rx_data_valid_in = 1'b0;
      rf_rd_data_in         = '0;
      rf_rd_data_valid_in   = 1'b0;
      alu_out_in            = '0;
      alu_out_valid_in      = 1'b0;
      idle(3);
      check("reset_outputs", all_outs(), 64'h0);
      reset = 1'b0;

      // RF write with gaps between bytes; upper address bits beyond ADDR are irrelevant here.
      send_byte(8'hAA);
      idle(2);
      send_byte(8'h05);
      idle(3);
      push(K_WR, 4'h5, 16'h003C);
      send_byte(8'h3C);
      idle(3);

      // Valids outside their wait states must be ignored.
      rf_rd_data_in = 8'hEE; rf_rd_data_valid_in = 1'b1;
      alu_out_in = 16'hBEEF; alu_out_valid_in = 1'b1;
      idle(1);
      rf_rd_data_valid_in = 1'b0; alu_out_valid_in = 1'b0;
      idle(2);

      // RF read of 0x13 -> address 3, data returned three cycles after the read strobe.
      send_byte(8'hBB);
      push(K_RD, 4'h3, 16'h0000);
      send_byte(8'h13);
      check("rd_addr", rf_addr_out, 64'h3);
      idle(2);
      push(K_RF_SEND, 4'h0, 16'h007E);
      rf_rd_data_in = 8'h7E; rf_rd_data_valid_in = 1'b1;
      idle(1);
      rf_rd_data_valid_in = 1'b0; rf_rd_data_in = 8'h00;
      idle(3);
      check("rf_send_hold", {uart_rf_send_out, uart_rf_send_data_out}, 64'h07E);

      // ALU with operands.
      send_byte(8'hCC);
      check("clk_gate_after_cc", clk_gate_en_out, 64'h1);
      push(K_WR, 4'h0, 16'h0012);
      send_byte(8'h12);
      push(K_WR, 4'h1, 16'h0034);
      send_byte(8'h34);
      push(K_ALU, 4'h0, 16'h0001);
      send_byte(8'h01);
      idle(4);
      check("clk_gate_in_wait", clk_gate_en_out, 64'h1);
      push(K_ALU_SEND, 4'h0, 16'h0046);
      alu_out_in = 16'h0046; alu_out_valid_in = 1'b1;
      idle(1);
      alu_out_valid_in = 1'b0; alu_out_in = 16'h0000;
      check("clk_gate_after_result", clk_gate_en_out, 64'h0);
      idle(2);
      check("alu_send_hold", {uart_alu_send_out, uart_alu_send_data_out}, 64'h00046);

      // ALU without operands, no result: timeout fires TIMEOUT+1 cycles after alu_en.
      send_byte(8'hDD);
      check("clk_gate_after_dd", clk_gate_en_out, 64'h1);
      push(K_ALU, 4'h0, 16'h0002);
      send_byte(8'h02);
      push(K_TO, 4'h0, 16'h0000);
      n = 0;
      for (int i = 1; i <= TIMEOUT + 50; i++) begin
         @(negedge clk);
         if (timeout_err_out) begin
            n = i;
            break;
         end
      end
      check("timeout_latency", n, 64'(TIMEOUT + 1));
      check("clk_gate_after_timeout", clk_gate_en_out, 64'h0);
      check("alu_fun_hold", alu_fun_out, 64'h2);
      idle(2);

      // Garbage command, then a read with a stray byte during the wait.
      send_byte(8'h55);
      idle(2);
      send_byte(8'hBB);
      push(K_RD, 4'h2, 16'h0000);
      send_byte(8'h02);
      send_byte(8'h99);
      idle(2);
      push(K_RF_SEND, 4'h0, 16'h00A5);
      rf_rd_data_in = 8'hA5; rf_rd_data_valid_in = 1'b1;
      idle(1);
      rf_rd_data_valid_in = 1'b0;
      idle(3);

      // Reset mid-frame, then 0x77 must be taken as an ignored command.
      send_byte(8'hAA);
      send_byte(8'h04);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      check("midframe_reset_outputs", all_outs(), 64'h0);
      reset = 1'b0;
      send_byte(8'h77);
      idle(2);
      send_byte(8'hAA);
      send_byte(8'h01);
      push(K_WR, 4'h1, 16'h0066);
      send_byte(8'h66);
      idle(5);

      check("scoreboard_drained", q.size(), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
